// File: rtl/div_ctrl.sv
// Execute-stage sequencer for the iterative 32-bit divider: issue, operand hold, capture, flush abort.
// Optional DIV_FAST_PATH_EN: divisors 0 and 1 are resolved in IDLE without starting the divider.
module div_ctrl #(
  parameter int TAG_W        = 5,
  parameter int ABORT_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_div_req_i,
  input  logic             ex_signed_i,
  input  logic             ex_rem_i,
  input  logic [31:0]      ex_opa_i,
  input  logic [31:0]      ex_opb_i,
  input  logic [TAG_W-1:0] ex_tag_i,
  input  logic             flush_i,
  input  logic             stall_i,
  output logic             stall_req_o,
  output logic             valid_o,
  output logic [31:0]      wdata_o,
  output logic [TAG_W-1:0] wtag_o,
  output logic             dbz_o,
  output logic             div_signed_o,
  output logic [31:0]      div_opdata1_o,
  output logic [31:0]      div_opdata2_o,
  output logic             div_start_o,
  output logic             div_annul_o,
  input  logic [63:0]      div_result_i,
  input  logic             div_ready_i
);

  localparam int CNT_W = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE, ABORT} state_t;

  state_t           state;
  logic             rem_sel;
  logic [CNT_W-1:0] abort_cnt;

  assign stall_req_o = ex_div_req_i & ~flush_i & (state != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rem_sel       <= 1'b0;
      abort_cnt     <= '0;
      valid_o       <= 1'b0;
      wdata_o       <= '0;
      wtag_o        <= '0;
      dbz_o         <= 1'b0;
      div_signed_o  <= 1'b0;
      div_opdata1_o <= '0;
      div_opdata2_o <= '0;
      div_start_o   <= 1'b0;
      div_annul_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_div_req_i && !flush_i) begin
            rem_sel       <= ex_rem_i;
            wtag_o        <= ex_tag_i;
            dbz_o         <= (ex_opb_i == '0);
            div_signed_o  <= ex_signed_i;
            div_opdata1_o <= ex_opa_i;
            div_opdata2_o <= ex_opb_i;
`ifdef DIV_FAST_PATH_EN
            // Divisor 0 or 1: the answer is known without iterating.
            if (ex_opb_i[31:1] == '0) begin
              wdata_o <= (ex_opb_i[0] && !ex_rem_i) ? ex_opa_i : '0;
              valid_o <= 1'b1;
              state   <= DONE;
            end else begin
              div_start_o <= 1'b1;
              state       <= RUN;
            end
`else
            div_start_o <= 1'b1;
            state       <= RUN;
`endif
          end
        end
        RUN: begin
          // Flush wins over a simultaneous ready: the result belongs to a killed instruction.
          if (flush_i) begin
            div_start_o <= 1'b0;
            div_annul_o <= 1'b1;
            abort_cnt   <= CNT_W'(ABORT_CYCLES - 1);
            state       <= ABORT;
          end else if (div_ready_i) begin
            wdata_o     <= rem_sel ? div_result_i[63:32] : div_result_i[31:0];
            div_start_o <= 1'b0;
            valid_o     <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (flush_i || !stall_i) begin
            valid_o <= 1'b0;
            state   <= IDLE;
          end
        end
        ABORT: begin
          if (abort_cnt == '0) begin
            div_annul_o <= 1'b0;
            state       <= IDLE;
          end else begin
            abort_cnt <= abort_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl with a behavioural divider model and arithmetic reference.
`timescale 1ns/1ps
module tb_div_ctrl;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_div_req_i, ex_signed_i, ex_rem_i;
  logic [31:0]      ex_opa_i, ex_opb_i;
  logic [TAG_W-1:0] ex_tag_i;
  logic             flush_i, stall_i;
  logic             stall_req_o, valid_o, dbz_o;
  logic [31:0]      wdata_o;
  logic [TAG_W-1:0] wtag_o;
  logic             div_signed_o, div_start_o, div_annul_o;
  logic [31:0]      div_opdata1_o, div_opdata2_o;
  logic [63:0]      div_result_i;
  logic             div_ready_i;

  int n_cmp = 0;
  int n_err = 0;
  int dcnt;

  div_ctrl #(.TAG_W(TAG_W), .ABORT_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .ex_div_req_i(ex_div_req_i), .ex_signed_i(ex_signed_i), .ex_rem_i(ex_rem_i),
    .ex_opa_i(ex_opa_i), .ex_opb_i(ex_opb_i), .ex_tag_i(ex_tag_i),
    .flush_i(flush_i), .stall_i(stall_i), .stall_req_o(stall_req_o),
    .valid_o(valid_o), .wdata_o(wdata_o), .wtag_o(wtag_o), .dbz_o(dbz_o),
    .div_signed_o(div_signed_o), .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_word(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn, input logic rm);
    if (b == 32'd0) return 32'd0;
    if (sgn) return rm ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rm ? (a % b) : (a / b);
  endfunction

  // Divider: ready 35 cycles after start is seen (3 for a zero divisor), operands read at the end.
  always @(posedge clk) begin
    if (rst || div_annul_o) begin
      dcnt <= 0; div_ready_i <= 1'b0; div_result_i <= '0;
    end else if (!div_start_o) begin
      dcnt <= 0; div_ready_i <= 1'b0;
    end else if (!div_ready_i) begin
      dcnt <= dcnt + 1;
      if (dcnt + 1 == ((div_opdata2_o == 32'd0) ? 3 : 35)) begin
        div_ready_i  <= 1'b1;
        div_result_i <= {ref_word(div_opdata1_o, div_opdata2_o, div_signed_o, 1'b1),
                         ref_word(div_opdata1_o, div_opdata2_o, div_signed_o, 1'b0)};
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                input logic rm, input logic [TAG_W-1:0] tg, input int hold);
    int lat, n;
    logic [31:0] exp;
    exp = ref_word(a, b, sgn, rm);
    lat = (b == 32'd0) ? 5 : 37;
`ifdef DIV_FAST_PATH_EN
    if (b <= 32'd1) lat = 1;
`endif
    ex_div_req_i = 1'b1; ex_signed_i = sgn; ex_rem_i = rm;
    ex_opa_i = a; ex_opb_i = b; ex_tag_i = tg;
    #1 check_output("stall_req_issue", stall_req_o, 1);
    n = 0;
    do begin
      tick(); n++;
      if (!valid_o) begin
        check_output("stall_req_busy", stall_req_o, 1);
        check_output("start_busy", div_start_o, 1);
        check_output("opa_held", div_opdata1_o, a);
        check_output("opb_held", div_opdata2_o, b);
        check_output("signed_held", div_signed_o, sgn);
      end
      // Garbage on the EX operand bus must not disturb the latched operation.
      if (n == 1) begin
        ex_opa_i = ~a; ex_opb_i = $urandom; ex_signed_i = ~sgn; ex_rem_i = ~rm; ex_tag_i = ~tg;
      end
    end while (!valid_o && n < 60);
    check_output("latency", n, lat);
    check_output("valid", valid_o, 1);
    check_output("wdata", wdata_o, exp);
    check_output("wtag", wtag_o, tg);
    check_output("dbz", dbz_o, b == 32'd0);
    check_output("start_done", div_start_o, 0);
    #1 check_output("stall_req_done", stall_req_o, 0);
    for (int i = 0; i < hold; i++) begin
      stall_i = 1'b1;
      tick();
      check_output("valid_stalled", valid_o, 1);
      check_output("wdata_stalled", wdata_o, exp);
      check_output("wtag_stalled", wtag_o, tg);
    end
    stall_i = 1'b0; ex_div_req_i = 1'b0;
    tick();
    check_output("valid_consumed", valid_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; ex_div_req_i = 1'b0; ex_signed_i = 1'b0; ex_rem_i = 1'b0;
    ex_opa_i = '0; ex_opb_i = '0; ex_tag_i = '0; flush_i = 1'b0; stall_i = 1'b0;
    tick(); tick();
    check_output("rst_valid", valid_o, 0);
    check_output("rst_wdata", wdata_o, 0);
    check_output("rst_start", div_start_o, 0);
    check_output("rst_annul", div_annul_o, 0);
    rst = 1'b0;
    tick();

    apply_stimulus(32'd100, 32'd7, 1'b0, 1'b0, 5'd5, 0);
    apply_stimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 5'd12, 0);
    apply_stimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 5'd13, 0);
    apply_stimulus(32'd1234, 32'd0, 1'b0, 1'b0, 5'd7, 0);
    apply_stimulus(32'hDEAD_BEEF, 32'd1, 1'b1, 1'b0, 5'd3, 0);
    apply_stimulus(32'hDEAD_BEEF, 32'd1, 1'b0, 1'b1, 5'd4, 1);
    apply_stimulus(32'd50, 32'd5, 1'b0, 1'b0, 5'd21, 3);

    // Flush ten cycles into a divide, with a fresh request waiting through the abort.
    ex_div_req_i = 1'b1; ex_signed_i = 1'b0; ex_rem_i = 1'b0;
    ex_opa_i = 32'h1234_5678; ex_opb_i = 32'd13; ex_tag_i = 5'd9;
    for (int i = 0; i < 10; i++) tick();
    flush_i = 1'b1; ex_div_req_i = 1'b0;
    #1 check_output("stall_req_flush", stall_req_o, 0);
    tick();
    flush_i = 1'b0; ex_div_req_i = 1'b1; ex_opa_i = 32'd9; ex_opb_i = 32'd3; ex_tag_i = 5'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_output("abort_annul", div_annul_o, 1);
      check_output("abort_start", div_start_o, 0);
      check_output("abort_stall_req", stall_req_o, 1);
      check_output("abort_valid", valid_o, 0);
      tick();
    end
    check_output("abort_end_annul", div_annul_o, 0);
    check_output("abort_end_start", div_start_o, 0);
    apply_stimulus(32'd9, 32'd3, 1'b0, 1'b0, 5'd2, 0);

    // Reset twenty cycles into a divide.
    ex_div_req_i = 1'b1; ex_signed_i = 1'b1; ex_rem_i = 1'b1;
    ex_opa_i = 32'd100000; ex_opb_i = 32'd7; ex_tag_i = 5'd9;
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1; ex_div_req_i = 1'b0;
    tick();
    check_output("mid_rst_valid", valid_o, 0);
    check_output("mid_rst_wdata", wdata_o, 0);
    check_output("mid_rst_wtag", wtag_o, 0);
    check_output("mid_rst_dbz", dbz_o, 0);
    check_output("mid_rst_start", div_start_o, 0);
    check_output("mid_rst_annul", div_annul_o, 0);
    check_output("mid_rst_signed", div_signed_o, 0);
    check_output("mid_rst_opa", div_opdata1_o, 0);
    check_output("mid_rst_opb", div_opdata2_o, 0);
    rst = 1'b0;
    tick();
    apply_stimulus(32'd10, 32'd3, 1'b0, 1'b0, 5'd17, 0);

    for (int k = 0; k < 8; k++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(0, 1);
        1:       rb = $urandom_range(2, 100);
        default: rb = $urandom;
      endcase
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      apply_stimulus(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     TAG_W'($urandom), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
